// File: rtl/dual_port_ram_clr_if.sv
// dual_port_ram_clr_if
//   Bus bundle for dual_port_ram_clr: CPU-side read/write port A, video-side
//   read-only port B, and the clear-sweep request/status pair.
//   master : drives addresses, write data, enables and clr_req; observes outputs
//   slave  : the RAM itself
//   a_addr/a_load/a_in/a_out   port A address, write enable, write data, read data
//   b_addr/b_en/b_out          port B address, read enable, read data
//   clr_req/busy               clear-sweep start pulse and sweep-in-progress flag
interface dual_port_ram_clr_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_load;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] a_out;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_en;
  logic [DATA_WIDTH-1:0] b_out;
  logic                  clr_req;
  logic                  busy;

  modport master (
    output a_addr, a_load, a_in, b_addr, b_en, clr_req,
    input  a_out, b_out, busy
  );

  modport slave (
    input  a_addr, a_load, a_in, b_addr, b_en, clr_req,
    output a_out, b_out, busy
  );
endinterface

// File: rtl/dual_port_ram_clr.sv
// dual_port_ram_clr
//   Synchronous block RAM with a read/write port A (CPU data side), a read-only
//   port B (screen scan side) and a clear sequencer that writes CLEAR_VALUE to
//   every word after reset release (optional) and on clr_req.
//   clk    : single clock, everything on the rising edge
//   rst_n  : synchronous active-low reset (memory contents are not touched)
//   bus    : dual_port_ram_clr_if slave modport (port A, port B, clr_req, busy)
module dual_port_ram_clr #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 14,
  parameter int                    RDW_MODE       = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_port_ram_clr_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_a_out;
  logic [DATA_WIDTH-1:0] r_b_out;
  logic                  r_busy;

  logic                  w_idle;
  logic                  w_a_wr;
  logic                  w_clr_wr;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_a_old;
  logic [DATA_WIDTH-1:0] w_b_old;

  // A single physical write port is shared by the CPU and the sweep: the
  // sweep owns it while clearing, and clr_req pre-empts a same-cycle CPU write.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_a_wr   = w_idle & bus.a_load & ~bus.clr_req;
  assign w_clr_wr = ~w_idle;
  // Reset must leave the contents alone, so no write lands while rst_n is low.
  assign w_we     = rst_n & (w_a_wr | w_clr_wr);
  assign w_waddr  = w_clr_wr ? r_clr_cnt : bus.a_addr;
  assign w_wdata  = w_clr_wr ? CLEAR_VALUE : bus.a_in;

  // Pre-write contents; registering these gives read-first behaviour on both
  // ports, including B reading the word A is writing.
  assign w_a_old = r_mem[bus.a_addr];
  assign w_b_old = r_mem[bus.b_addr];

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_out   <= '0;
      r_b_out   <= '0;
      r_clr_cnt <= '0;
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_busy    <= (CLEAR_ON_RESET != 0);
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Write-first forwarding only applies to a write that actually lands.
          if ((RDW_MODE != 0) && w_a_wr) begin
            r_a_out <= bus.a_in;
          end else begin
            r_a_out <= w_a_old;
          end
          if (bus.b_en) begin
            r_b_out <= w_b_old;
          end
          if (bus.clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Outputs hold and all requests are ignored while sweeping.
          r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          if (r_clr_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.a_out = r_a_out;
  assign bus.b_out = r_b_out;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// tb_dual_port_ram_clr
//   Drives three RAM instances from one shared stimulus stream:
//     dut 0: RDW_MODE=0, CLEAR_ON_RESET=1
//     dut 1: RDW_MODE=1, CLEAR_ON_RESET=1
//     dut 2: RDW_MODE=0, CLEAR_ON_RESET=0
//   A word-level reference model predicts busy/a_out/b_out for each instance;
//   directed scenarios add hand-computed literal expectations.
module tb_dual_port_ram_clr;
  localparam int             AW = 4;
  localparam int             DW = 16;
  localparam int             N  = 16;
  localparam logic [DW-1:0]  CV = 16'hA5A5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] a_addr;
  logic          a_load;
  logic [DW-1:0] a_in;
  logic [AW-1:0] b_addr;
  logic          b_en;
  logic          clr_req;

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dual_port_ram_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    assign bus.a_addr  = a_addr;
    assign bus.a_load  = a_load;
    assign bus.a_in    = a_in;
    assign bus.b_addr  = b_addr;
    assign bus.b_en    = b_en;
    assign bus.clr_req = clr_req;
    dual_port_ram_clr #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .RDW_MODE      ((gi == 1) ? 1 : 0),
      .CLEAR_ON_RESET((gi == 2) ? 0 : 1),
      .CLEAR_VALUE   (CV)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  function automatic logic busy_of(int d);
    case (d)
      0: return g_dut[0].bus.busy;
      1: return g_dut[1].bus.busy;
      default: return g_dut[2].bus.busy;
    endcase
  endfunction

  function automatic logic [DW-1:0] aout_of(int d);
    case (d)
      0: return g_dut[0].bus.a_out;
      1: return g_dut[1].bus.a_out;
      default: return g_dut[2].bus.a_out;
    endcase
  endfunction

  function automatic logic [DW-1:0] bout_of(int d);
    case (d)
      0: return g_dut[0].bus.b_out;
      1: return g_dut[1].bus.b_out;
      default: return g_dut[2].bus.b_out;
    endcase
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Word-level view: a sweep is just "busy for N cycles, then every word reads
  // CLEAR_VALUE"; nothing is observable in between because outputs hold.
  logic [DW-1:0] mm    [3][N];
  bit            kn    [3][N];
  int            busy_left [3];
  logic [DW-1:0] ea [3];
  logic [DW-1:0] eb [3];
  bit            ea_kn [3];
  bit            eb_kn [3];
  bit            started = 1'b0;

  initial begin
    for (int d = 0; d < 3; d++) begin
      busy_left[d] = 0;
      ea_kn[d] = 1'b0;
      eb_kn[d] = 1'b0;
      for (int k = 0; k < N; k++) kn[d][k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic [DW-1:0] old_a;
      logic [DW-1:0] old_b;
      bit            old_a_kn;
      bit            old_b_kn;
      if (!rst_n) begin
        // An interrupted sweep with no auto-clear leaves a partly cleared memory.
        if (d == 2 && busy_left[d] != 0)
          for (int k = 0; k < N; k++) kn[d][k] = 1'b0;
        busy_left[d] = (d != 2) ? N : 0;
        ea[d] = '0;
        eb[d] = '0;
        ea_kn[d] = 1'b1;
        eb_kn[d] = 1'b1;
      end else if (busy_left[d] != 0) begin
        busy_left[d]--;
        if (busy_left[d] == 0)
          for (int k = 0; k < N; k++) begin
            mm[d][k] = CV;
            kn[d][k] = 1'b1;
          end
      end else begin
        old_a    = mm[d][a_addr];
        old_a_kn = kn[d][a_addr];
        old_b    = mm[d][b_addr];
        old_b_kn = kn[d][b_addr];
        if (b_en) begin
          eb[d]    = old_b;
          eb_kn[d] = old_b_kn;
        end
        if (clr_req) begin
          busy_left[d] = N;
          ea[d]    = old_a;
          ea_kn[d] = old_a_kn;
        end else if (a_load) begin
          ea[d]    = (d == 1) ? a_in : old_a;
          ea_kn[d] = (d == 1) ? 1'b1 : old_a_kn;
          mm[d][a_addr] = a_in;
          kn[d][a_addr] = 1'b1;
        end else begin
          ea[d]    = old_a;
          ea_kn[d] = old_a_kn;
        end
      end
    end
    if (!rst_n) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("model_busy%0d", d), {15'b0, busy_of(d)}, {15'b0, busy_left[d] != 0});
        if (ea_kn[d]) check($sformatf("model_a_out%0d", d), aout_of(d), ea[d]);
        if (eb_kn[d]) check($sformatf("model_b_out%0d", d), bout_of(d), eb[d]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic [AW-1:0] aa, input logic ld, input logic [DW-1:0] ai,
                       input logic [AW-1:0] ba, input logic be, input logic cr);
    a_addr = aa; a_load = ld; a_in = ai; b_addr = ba; b_en = be; clr_req = cr;
    $display("txn rst_n=%0b a_addr=%0d a_load=%0b a_in=%h b_addr=%0d b_en=%0b clr_req=%0b",
             rst_n, aa, ld, ai, ba, be, cr);
    @(negedge clk);
  endtask

  // Counts negedges with busy high, starting at the current negedge.
  task automatic count_busy(input int d, output int n);
    n = 0;
    while (busy_of(d) && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) cycle(AW'(i), 1'b0, '0, AW'(N - 1 - i), 1'b1, 1'b0);
  endtask

  int nb;

  initial begin
    rst_n = 1'b0;
    a_addr = '0; a_load = 1'b0; a_in = '0; b_addr = '0; b_en = 1'b0; clr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_a_out", g_dut[0].bus.a_out, 16'h0000);
    check("rst_b_out", g_dut[1].bus.b_out, 16'h0000);
    check("rst_busy_cor0", {15'b0, g_dut[2].bus.busy}, 16'h0000);

    // 1. power-up sweep
    rst_n = 1'b1;
    count_busy(0, nb);
    check("sweep_len_reset", 16'(nb), 16'd16);
    read_all();
    check("sweep_a15", g_dut[0].bus.a_out, CV);
    check("sweep_b0", g_dut[1].bus.b_out, CV);

    // 2. write then read
    cycle(4'd3, 1'b1, 16'h1234, 4'd0, 1'b0, 1'b0);
    cycle(4'd3, 1'b0, 16'h0000, 4'd3, 1'b1, 1'b0);
    check("wr_rd_a", g_dut[0].bus.a_out, 16'h1234);
    check("wr_rd_b", g_dut[0].bus.b_out, 16'h1234);
    cycle(4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    check("b_hold", g_dut[0].bus.b_out, 16'h1234);

    // 3. read-during-write and collision
    cycle(4'd5, 1'b1, 16'h0001, 4'd0, 1'b0, 1'b0);
    cycle(4'd5, 1'b1, 16'h00FF, 4'd5, 1'b1, 1'b0);
    check("rdw0_a", g_dut[0].bus.a_out, 16'h0001);
    check("rdw1_a", g_dut[1].bus.a_out, 16'h00FF);
    check("coll0_b", g_dut[0].bus.b_out, 16'h0001);
    check("coll1_b", g_dut[1].bus.b_out, 16'h0001);
    cycle(4'd5, 1'b0, 16'h0000, 4'd5, 1'b1, 1'b0);
    check("rdw_after", g_dut[0].bus.a_out, 16'h00FF);

    // 4. requests during a sweep are ignored
    cycle(4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
    nb = 0;
    while (g_dut[0].bus.busy && nb < 100) begin
      nb++;
      if (nb <= 5) begin
        a_load = 1'b1; a_addr = 4'd2; a_in = 16'hBEEF; clr_req = 1'b1;
      end else begin
        a_load = 1'b0; clr_req = 1'b0;
      end
      @(negedge clk);
    end
    check("sweep_len_ignored", 16'(nb), 16'd16);
    cycle(4'd2, 1'b0, 16'h0000, 4'd2, 1'b1, 1'b0);
    check("ignored_wr_a", g_dut[0].bus.a_out, CV);
    check("ignored_wr_b", g_dut[1].bus.b_out, CV);
    check("model_mem2", mm[0][2], CV);

    // 5. reset in the middle of a sweep restarts it
    cycle(4'd12, 1'b1, 16'h1111, 4'd0, 1'b0, 1'b0);
    cycle(4'd9,  1'b1, 16'h2222, 4'd0, 1'b0, 1'b0);
    cycle(4'd0,  1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(4'd0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("mid_rst_busy_cor0", {15'b0, g_dut[2].bus.busy}, 16'h0000);
    count_busy(0, nb);
    check("sweep_len_restart", 16'(nb), 16'd16);
    read_all();
    cycle(4'd12, 1'b0, 16'h0000, 4'd9, 1'b1, 1'b0);
    check("restart_a12", g_dut[0].bus.a_out, CV);
    check("restart_b9", g_dut[1].bus.b_out, CV);

    // 6. clr_req beats a same-cycle write (no auto-clear instance)
    cycle(4'd1, 1'b1, 16'h7777, 4'd0, 1'b0, 1'b1);
    count_busy(2, nb);
    check("sweep_len_req", 16'(nb), 16'd16);
    cycle(4'd1, 1'b0, 16'h0000, 4'd1, 1'b1, 1'b0);
    check("dropped_wr_a", g_dut[2].bus.a_out, CV);
    check("dropped_wr_b", g_dut[2].bus.b_out, CV);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
